// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer, mode 0, full duplex, MSB-first by default.
// Optional SPI_LSB_FIRST_EN adds cmd_lsb_first for LSB-first transfers.
module spi_xfer_ctrl #(
    parameter int SS_NUM = 8,
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8,
    localparam int SS_W  = $clog2(SS_NUM),
    localparam int LEN_W = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SS_W-1:0]   cmd_ss,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic [DATA_W-1:0] cmd_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic              cmd_lsb_first,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [SS_NUM-1:0] ss_pad_o,
    output logic              sclk_pad_o,
    output logic              mosi_pad_o,
    input  logic              miso_pad_i
);

    typedef enum logic [2:0] {
        IDLE, LEAD, SCK_H, SCK_L, TRAIL
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

    state_t            state, state_d;
    logic [DIV_W-1:0]  cnt, div_q;
    logic [LEN_W-1:0]  len_q, bit_cnt, eff_len;
    logic [DATA_W-1:0] tx_q, rx_q, tx_msb;
    logic              lsb_q, lsb_in, accept, done, last_bit;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = cmd_lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_ready & cmd_valid;
    assign done      = (cnt == '0);
    assign last_bit  = (bit_cnt == len_q);

    // Zero or oversize length means a full-width word; MSB-first data is
    // left-aligned so the first bit always sits at the top of tx_msb.
    assign eff_len = (cmd_len == '0 || cmd_len > FULL_LEN) ? FULL_LEN : cmd_len;
    assign tx_msb  = cmd_data << (FULL_LEN - eff_len);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state: every non-idle state lasts div+1 cycles
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_d = LEAD;
            LEAD:    if (done) state_d = SCK_H;
            SCK_H:   if (done) state_d = last_bit ? TRAIL : SCK_L;
            SCK_L:   if (done) state_d = SCK_H;
            TRAIL:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: command latch, half-period counter, shifters and pads
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_q      <= '0;
            len_q      <= '0;
            bit_cnt    <= '0;
            lsb_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            ss_pad_o   <= '1;
            sclk_pad_o <= 1'b0;
            mosi_pad_o <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                cnt        <= cmd_div;
                div_q      <= cmd_div;
                len_q      <= eff_len;
                lsb_q      <= lsb_in;
                bit_cnt    <= '0;
                rx_q       <= '0;
                ss_pad_o   <= ~(SS_NUM'(1) << cmd_ss);
                sclk_pad_o <= 1'b0;
                mosi_pad_o <= lsb_in ? cmd_data[0] : tx_msb[DATA_W-1];
                tx_q       <= lsb_in ? (cmd_data >> 1) : (tx_msb << 1);
            end else if (state != IDLE) begin
                if (!done) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt <= div_q;
                    case (state)
                        LEAD, SCK_L: begin
                            sclk_pad_o <= 1'b1;
                            bit_cnt    <= bit_cnt + 1'b1;
                            rx_q <= lsb_q ? {miso_pad_i, rx_q[DATA_W-1:1]}
                                          : {rx_q[DATA_W-2:0], miso_pad_i};
                        end
                        SCK_H: begin
                            sclk_pad_o <= 1'b0;
                            if (!last_bit) begin
                                mosi_pad_o <= lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                                tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
                            end
                        end
                        TRAIL: begin
                            ss_pad_o  <= '1;
                            rsp_valid <= 1'b1;
                            rsp_data  <= lsb_q ? (rx_q >> (FULL_LEN - len_q))
                                               : rx_q;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: scoreboard of expected transfers
// popped on rsp_valid, plus pad-level timing capture.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ss = '0;
    logic [5:0]  cmd_len = '0;
    logic [7:0]  cmd_div = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_lsb_first = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [7:0]  ss_pad_o;
    logic        sclk_pad_o;
    logic        mosi_pad_o;
    logic        miso_pad_i;
    logic        loop_en = 1'b1;
    logic        miso_tie = 1'b0;

    assign miso_pad_i = loop_en ? mosi_pad_o : miso_tie;

    always #5 clk = ~clk;

    spi_xfer_ctrl dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ss(cmd_ss),
        .cmd_len(cmd_len),
        .cmd_div(cmd_div),
        .cmd_data(cmd_data),
`ifdef SPI_LSB_FIRST_EN
        .cmd_lsb_first(cmd_lsb_first),
`endif
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .ss_pad_o(ss_pad_o),
        .sclk_pad_o(sclk_pad_o),
        .mosi_pad_o(mosi_pad_o),
        .miso_pad_i(miso_pad_i)
    );

    typedef struct {
        logic [31:0] rx;
        logic [31:0] mw;
        int          low;
        int          pulses;
        int          hi;
        logic [7:0]  ss;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // monitor state
    int          m_low, m_pulses, m_hirun, m_himin, m_himax, m_gap, m_last_gap;
    logic [31:0] m_mw;
    logic [7:0]  m_ss;
    logic        m_in, m_psclk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Pad monitor, sampled on the falling edge
    initial begin
        m_in = 0; m_psclk = 0; m_gap = 0; m_last_gap = 0;
        m_low = 0; m_pulses = 0; m_hirun = 0; m_himin = 0; m_himax = 0;
        m_mw = '0; m_ss = '1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_in = 0; m_gap = 0; m_psclk = 0; m_hirun = 0;
            end else begin
                if (ss_pad_o != 8'hFF) begin
                    if (!m_in) begin
                        m_in = 1; m_last_gap = m_gap; m_gap = 0;
                        m_low = 0; m_pulses = 0; m_mw = '0;
                        m_hirun = 0; m_himin = 1000; m_himax = 0;
                        m_ss = ss_pad_o;
                    end
                    m_low++;
                    if (ss_pad_o != m_ss) m_ss = 8'h00;
                    if (sclk_pad_o && !m_psclk) begin
                        m_pulses++;
                        m_mw = {m_mw[30:0], mosi_pad_o};
                    end
                    if (sclk_pad_o) m_hirun++;
                    else if (m_psclk) begin
                        if (m_hirun < m_himin) m_himin = m_hirun;
                        if (m_hirun > m_himax) m_himax = m_hirun;
                        m_hirun = 0;
                    end
                end else begin
                    m_in = 0;
                    m_gap++;
                end
                m_psclk = sclk_pad_o;
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_data", rsp_data, e.rx);
                        check("mosi_bits", m_mw, e.mw);
                        check("ss_low_cycles", m_low, e.low);
                        check("sclk_pulses", m_pulses, e.pulses);
                        check("sclk_hi_min", m_himin, e.hi);
                        check("sclk_hi_max", m_himax, e.hi);
                        check("ss_pattern", m_ss, e.ss);
                        check("busy_vs_ready", busy, !cmd_ready);
                    end
                end
            end
        end
    end

    // Drive a command, hold it until accepted, push its expectation
    task automatic send(input logic [2:0] ss, input logic [5:0] len,
                        input logic [7:0] div, input logic [31:0] data,
                        input logic lsb);
        exp_t e;
        int   n;
        logic [63:0] mask;
        logic [31:0] mw;
        bit   ok;
        n    = (len == 0) ? 32 : int'(len);
        mask = (64'd1 << n) - 1;
        mw   = '0;
        for (int i = 0; i < n; i++)
            mw[n-1-i] = lsb ? data[i] : data[n-1-i];
        e.mw     = mw;
        e.rx     = loop_en ? data & mask[31:0] : (miso_tie ? mask[31:0] : '0);
        e.low    = (2 * n + 1) * (int'(div) + 1);
        e.pulses = n;
        e.hi     = int'(div) + 1;
        e.ss     = ~(8'd1 << ss);
        @(negedge clk);
        cmd_ss = ss; cmd_len = len; cmd_div = div;
        cmd_data = data; cmd_lsb_first = lsb; cmd_valid = 1'b1;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 1, 0);
        else     sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 5000 && sb.size() != 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int   rises, nrsp;
        logic ps;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", ss_pad_o, 8'hFF);
        check("rst_sclk", sclk_pad_o, 0);
        check("rst_mosi", mosi_pad_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // loopback, 8 bits, fastest clock
        loop_en = 1;
        send(3'd2, 6'd8, 8'd0, 32'hA5, 1'b0);
        drain();
        check("hold_rsp_data", rsp_data, 32'hA5);

        // miso tied high, full 32-bit word, div=1
        loop_en = 0; miso_tie = 1;
        send(3'd0, 6'd0, 8'd1, 32'hDEADBEEF, 1'b0);
        drain();

        // miso tied low, 5 bits, div=3
        miso_tie = 0;
        send(3'd7, 6'd5, 8'd3, 32'h1F, 1'b0);
        drain();

        // back-to-back commands
        loop_en = 1;
        send(3'd4, 6'd8, 8'd0, 32'h3C, 1'b0);
        send(3'd4, 6'd8, 8'd0, 32'hC3, 1'b0);
        drain();
        check("b2b_gap", m_last_gap, 1);

        // reset in SCK_H of bit 3
        send(3'd1, 6'd8, 8'd0, 32'h5A, 1'b0);
        rises = 0; ps = sclk_pad_o;
        for (int c = 0; c < 200; c++) begin
            if (sclk_pad_o && !ps) rises++;
            ps = sclk_pad_o;
            if (rises == 3 && sclk_pad_o) break;
            @(negedge clk);
        end
        check("rst_reach_bit3", rises, 3);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_ss", ss_pad_o, 8'hFF);
        check("midrst_sclk", sclk_pad_o, 0);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        nrsp = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("midrst_no_rsp", nrsp, 0);
        send(3'd3, 6'd4, 8'd2, 32'h9, 1'b0);
        drain();

`ifdef SPI_LSB_FIRST_EN
        send(3'd5, 6'd8, 8'd0, 32'h01, 1'b1);
        drain();
        send(3'd6, 6'd6, 8'd1, 32'h2D, 1'b1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
